// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: receiver state encoding, transmitter timing and
// the receiver defaults derived from that timing.
package ws2812_pkg;

  typedef enum logic [1:0] {StSync, StIdle, StHigh, StLow} state_e;

  // Transmitter timing in clock cycles
  localparam int unsigned T_HIGH = 13;
  localparam int unsigned T_DATA = 36;
  localparam int unsigned T_LOW  = 13;
  localparam int unsigned T_GAP  = 18000;

  // Midpoint between a short (0) and a long (1) transmitted high pulse
  localparam int unsigned BIT_THRESHOLD_DEF = (T_HIGH + (T_HIGH + T_DATA)) / 2;
  localparam int unsigned MAX_WORDS_DEF     = 1305;

endpackage

// File: rtl/ws2812_line_sync.sv
// Two-flop synchronizer for the asynchronous data line, a delay flop, and
// registered one-cycle rise/fall strobes aligned with the delayed level.
module ws2812_line_sync (
  input  logic clock,
  input  logic reset,
  input  logic din_i,
  output logic line_o,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic dly_q, dly_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    sync1_d = din_i;
    sync2_d = sync1_q;
    dly_d   = sync2_q;
    rise_d  = sync2_q & ~dly_q;
    fall_d  = ~sync2_q & dly_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      dly_q   <= dly_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign line_o = dly_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/ws2812_in.sv
// WS2812 receiver: classifies high pulses into bits, assembles MSB-first
// 16-bit words onto a strobe/address/data port and reports per-frame status.
module ws2812_in import ws2812_pkg::*; #(
  parameter int unsigned HIGH_MIN      = 4,
  parameter int unsigned BIT_THRESHOLD = BIT_THRESHOLD_DEF,
  parameter int unsigned HIGH_MAX      = 60,
  parameter int unsigned GAP_CYCLES    = 2400,
  parameter int unsigned MAX_WORDS     = MAX_WORDS_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        din,
  output logic [15:0] word_data,
  output logic [10:0] word_address,
  output logic        word_strobe,
  output logic        frame_done,
  output logic [11:0] frame_words,
  output logic        frame_error,
  output logic        busy
);

  localparam logic [16:0] HighMinW   = 17'(HIGH_MIN);
  localparam logic [16:0] ThreshW    = 17'(BIT_THRESHOLD);
  localparam logic [16:0] HighMaxW   = 17'(HIGH_MAX);
  localparam logic [16:0] GapW       = 17'(GAP_CYCLES);
  localparam logic [11:0] MaxWordsW  = 12'(MAX_WORDS);

  logic line, rise, fall;

  ws2812_line_sync u_line_sync (
    .clock  (clock),
    .reset  (reset),
    .din_i  (din),
    .line_o (line),
    .rise_o (rise),
    .fall_o (fall)
  );

  state_e      state_q, state_d;
  logic [15:0] pulse_cnt_q, pulse_cnt_d;
  logic [15:0] shift_q, shift_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [10:0] addr_q, addr_d;
  logic [11:0] word_cnt_q, word_cnt_d;
  logic        err_q, err_d;
  logic        pend_q, pend_d;
  logic        word_strobe_q, word_strobe_d;
  logic [15:0] word_data_q, word_data_d;
  logic        frame_done_q, frame_done_d;
  logic [11:0] frame_words_q, frame_words_d;
  logic        frame_error_q, frame_error_d;

  // Counter is cleared by the edge strobe, so the pulse length is count + 1
  logic [16:0] width;
  logic        gap_reached;
  assign width       = {1'b0, pulse_cnt_q} + 17'd1;
  assign gap_reached = (width >= GapW);

  always_comb begin
    state_d       = state_q;
    pulse_cnt_d   = (rise || fall) ? 16'd0 :
                    ((pulse_cnt_q == 16'hFFFF) ? pulse_cnt_q : pulse_cnt_q + 16'd1);
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    addr_d        = word_strobe_q ? addr_q + 11'd1 : addr_q;
    word_cnt_d    = word_cnt_q;
    err_d         = err_q;
    pend_d        = 1'b0;
    word_strobe_d = pend_q;
    word_data_d   = pend_q ? shift_q : word_data_q;
    frame_done_d  = 1'b0;
    frame_words_d = frame_words_q;
    frame_error_d = frame_error_q;

    unique case (state_q)
      StSync: begin
        if (!line && gap_reached) begin
          state_d = StIdle;
          // Only a frame aborted by an error reports on the resync gap
          if (err_q) begin
            frame_done_d  = 1'b1;
            frame_words_d = word_cnt_q;
            frame_error_d = 1'b1;
          end
          addr_d     = 11'd0;
          bit_cnt_d  = 4'd0;
          word_cnt_d = 12'd0;
          err_d      = 1'b0;
        end
      end
      StIdle: begin
        if (rise) state_d = StHigh;
      end
      StHigh: begin
        if (fall) begin
          if (width < HighMinW || width > HighMaxW) begin
            err_d   = 1'b1;
            state_d = StSync;
          end else begin
            shift_d   = {shift_q[14:0], (width >= ThreshW)};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd15) begin
              word_cnt_d = word_cnt_q + 12'd1;
              if ({1'b0, addr_q} >= MaxWordsW) err_d = 1'b1;
              else pend_d = 1'b1;
            end
            state_d = StLow;
          end
        end else if (width > HighMaxW) begin
          err_d   = 1'b1;
          state_d = StSync;
        end
      end
      StLow: begin
        if (rise) begin
          state_d = StHigh;
        end else if (gap_reached) begin
          state_d       = StIdle;
          frame_done_d  = 1'b1;
          frame_words_d = word_cnt_q;
          frame_error_d = err_q || (bit_cnt_q != 4'd0);
          addr_d        = 11'd0;
          bit_cnt_d     = 4'd0;
          word_cnt_d    = 12'd0;
          err_d         = 1'b0;
        end
      end
      default: state_d = StSync;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StSync;
      pulse_cnt_q   <= 16'd0;
      shift_q       <= 16'd0;
      bit_cnt_q     <= 4'd0;
      addr_q        <= 11'd0;
      word_cnt_q    <= 12'd0;
      err_q         <= 1'b0;
      pend_q        <= 1'b0;
      word_strobe_q <= 1'b0;
      word_data_q   <= 16'd0;
      frame_done_q  <= 1'b0;
      frame_words_q <= 12'd0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pulse_cnt_q   <= pulse_cnt_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      addr_q        <= addr_d;
      word_cnt_q    <= word_cnt_d;
      err_q         <= err_d;
      pend_q        <= pend_d;
      word_strobe_q <= word_strobe_d;
      word_data_q   <= word_data_d;
      frame_done_q  <= frame_done_d;
      frame_words_q <= frame_words_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign word_data    = word_data_q;
  assign word_address = addr_q;
  assign word_strobe  = word_strobe_q;
  assign frame_done   = frame_done_q;
  assign frame_words  = frame_words_q;
  assign frame_error  = frame_error_q;
  assign busy         = (state_q == StHigh) || (state_q == StLow);

endmodule

// File: tb/tb_ws2812_in.sv
// Randomized bench for ws2812_in: a pulse-level frame model pushes expected
// words and frame reports into queues; a monitor pops them on DUT strobes.
module tb_ws2812_in;
  import ws2812_pkg::*;

  localparam int MaxW = 4;
  localparam int Gap  = 2400;

  logic        clock = 1'b0;
  logic        reset;
  logic        din;
  logic [15:0] word_data;
  logic [10:0] word_address;
  logic        word_strobe;
  logic        frame_done;
  logic [11:0] frame_words;
  logic        frame_error;
  logic        busy;

  ws2812_in #(
    .HIGH_MIN      (4),
    .BIT_THRESHOLD (31),
    .HIGH_MAX      (60),
    .GAP_CYCLES    (Gap),
    .MAX_WORDS     (MaxW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .din          (din),
    .word_data    (word_data),
    .word_address (word_address),
    .word_strobe  (word_strobe),
    .frame_done   (frame_done),
    .frame_words  (frame_words),
    .frame_error  (frame_error),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {int addr; int data; int at;} word_t;
  typedef struct {int words; int err; int at;} frame_t;
  word_t  wq[$];
  frame_t fq[$];

  int n_checks = 0;
  int n_err    = 0;

  // Frame model state
  int m_sync = 1, m_errp = 0, m_bits = 0, m_bitcnt = 0, m_shift = 0;
  int m_words = 0, m_addr = 0, m_err = 0, last_fall = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clock) begin : monitor
    word_t  w;
    frame_t f;
    if (word_strobe === 1'b1) begin
      if (wq.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_strobe: got address %0d data %h expected none",
                 word_address, word_data);
      end else begin
        w = wq.pop_front();
        check("strobe_addr", 32'(word_address), w.addr);
        check("strobe_data", 32'(word_data), w.data);
        check("strobe_cycle", cyc, w.at);
      end
    end
    if (frame_done === 1'b1) begin
      if (fq.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_frame_done: got words %0d error %0d expected none",
                 frame_words, frame_error);
      end else begin
        f = fq.pop_front();
        check("frame_words", 32'(frame_words), f.words);
        check("frame_error", 32'(frame_error), f.err);
        check("frame_cycle", cyc, f.at);
      end
    end
  end

  task automatic model_bit(input int hw);
    word_t w;
    if (m_sync != 0) return;
    if (hw < 4 || hw > 60) begin
      m_sync = 1;
      m_errp = 1;
      return;
    end
    m_bits++;
    m_shift  = ((m_shift << 1) | ((hw >= 31) ? 1 : 0)) & 32'hFFFF;
    m_bitcnt = m_bitcnt + 1;
    if (m_bitcnt == 16) begin
      m_bitcnt = 0;
      m_words++;
      if (m_addr < MaxW) begin
        w.addr = m_addr;
        w.data = m_shift;
        w.at   = last_fall + 4;
        wq.push_back(w);
        m_addr++;
      end else begin
        m_err = 1;
      end
    end
  endtask

  // Called at a negedge; leaves the line low and returns at a negedge
  task automatic send_bit(input int hw, input int lw);
    din = 1'b1;
    repeat (hw) @(negedge clock);
    din = 1'b0;
    last_fall = cyc + 1;
    model_bit(hw);
    repeat (lw) @(negedge clock);
  endtask

  task automatic send_rand_bit(input bit b);
    int hw;
    hw = b ? int'($urandom_range(60, 31)) : int'($urandom_range(30, 4));
    send_bit(hw, int'($urandom_range(20, 2)));
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) send_rand_bit(w[i]);
  endtask

  task automatic send_gap();
    frame_t f;
    din = 1'b0;
    f.words = m_words;
    f.at    = last_fall + Gap + 3;
    if (m_sync != 0) begin
      if (m_errp != 0) begin
        f.err = 1;
        fq.push_back(f);
      end
    end else if (m_bits > 0) begin
      f.err = (m_err != 0 || m_bitcnt != 0) ? 1 : 0;
      fq.push_back(f);
    end
    m_sync = 0; m_errp = 0; m_bits = 0; m_bitcnt = 0;
    m_words = 0; m_addr = 0; m_err = 0;
    repeat (Gap + 30) @(negedge clock);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_word_data"}, 32'(word_data), 0);
    check({tag, "_word_address"}, 32'(word_address), 0);
    check({tag, "_word_strobe"}, 32'(word_strobe), 0);
    check({tag, "_frame_done"}, 32'(frame_done), 0);
    check({tag, "_frame_words"}, 32'(frame_words), 0);
    check({tag, "_frame_error"}, 32'(frame_error), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    logic [15:0] pat;
    int          sweep [4];
    int          nw;
    sweep = '{4, 30, 31, 60};
    din   = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b0;
    send_gap();

    // Single word with transmitter-shaped pulses
    pat = 16'hA5C3;
    for (int i = 15; i >= 0; i--) begin
      if (pat[i]) send_bit(int'(T_HIGH + T_DATA), int'(T_LOW));
      else send_bit(int'(T_HIGH), int'(T_DATA + T_LOW));
    end
    check("busy_mid_frame", 32'(busy), 1);
    send_gap();
    check("busy_after_gap", 32'(busy), 0);
    check("frame_words_held", 32'(frame_words), 1);

    // Full frame, then one word over the limit
    for (int i = 0; i < MaxW; i++) send_word(16'($urandom));
    send_gap();
    for (int i = 0; i < MaxW + 1; i++) send_word(16'($urandom));
    send_gap();

    // Width boundaries: legal extremes inside a word, then both error widths
    for (int i = 0; i < 16; i++) send_bit(sweep[i % 4], 5);
    send_gap();
    send_word(16'($urandom));
    send_bit(3, 10);
    send_gap();
    send_word(16'($urandom));
    send_bit(61, 10);
    send_gap();

    // Trailing partial word
    send_word(16'($urandom));
    for (int i = 0; i < 4; i++) send_rand_bit(1'($urandom));
    send_gap();

    // Reset mid-word, then a frame observed from its middle
    for (int i = 0; i < 5; i++) send_rand_bit(1'($urandom));
    reset = 1'b1;
    din   = 1'b0;
    @(negedge clock);
    check_reset_outputs("midreset");
    reset  = 1'b0;
    m_sync = 1; m_errp = 0; m_bits = 0; m_bitcnt = 0;
    m_words = 0; m_addr = 0; m_err = 0;
    for (int i = 0; i < 10; i++) send_rand_bit(1'($urandom));
    send_gap();
    send_word(16'($urandom));
    send_gap();

    // Random frames
    for (int k = 0; k < 3; k++) begin
      nw = int'($urandom_range(3, 1));
      for (int i = 0; i < nw; i++) send_word(16'($urandom));
      send_gap();
    end

    check("pending_words", wq.size(), 0);
    check("pending_frames", fq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
